// File: rtl/seg7_scan.sv
// -----------------------------------------------------------------------------
// seg7_scan
//
// Time-multiplexed driver for a multi-digit common-bus 7-segment display.
// A value of NDIGITS nibbles is captured into a shadow register on `load` and
// copied to the active register only at a frame boundary. A displayed frame
// therefore never mixes old and new digits. One digit is scanned per refresh
// slot. Each nibble is decoded as a hex glyph or as a grade letter (A/F/P).
// Per-digit blanking, blinking and leading-zero suppression darken a digit's
// segments. The digit enable still asserts, which keeps brightness constant.
//
// Parameters
//   NDIGITS      digits scanned (1..8)
//   REFRESH_DIV  clk_2 cycles per digit slot (>=2)
//   BLINK_FRAMES full scan frames per blink half-period (>=1)
//
// Ports
//   clk_2   in   single clock, rising edge
//   reset   in   asynchronous, active-low reset
//   value   in   [4*NDIGITS] nibble k = digit k (digit 0 rightmost)
//   load    in   strobe: capture value/dp into the shadow register
//   dp      in   [NDIGITS] decimal-point request per digit
//   mode    in   0 = hex glyphs, 1 = grade letters
//   blank   in   [NDIGITS] 1 = digit forced dark
//   blink   in   [NDIGITS] 1 = digit dark during blink phase 1
//   lzs     in   leading-zero suppression enable (hex mode only)
//   SEG     out  [8] SEG[6:0] = segments g..a, SEG[7] = dp, active-high
//   DIG     out  [NDIGITS] one-hot digit enable, active-high
//   frame   out  one-cycle pulse aligned with the first slot of each frame
// -----------------------------------------------------------------------------
module seg7_scan #(
   parameter int NDIGITS      = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                   clk_2,
   input  logic                   reset,
   input  logic [4*NDIGITS-1:0]   value,
   input  logic                   load,
   input  logic [NDIGITS-1:0]     dp,
   input  logic                   mode,
   input  logic [NDIGITS-1:0]     blank,
   input  logic [NDIGITS-1:0]     blink,
   input  logic                   lzs,
   output logic [7:0]             SEG,
   output logic [NDIGITS-1:0]     DIG,
   output logic                   frame
);

   localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIGITS - 1);
   localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_FRAMES - 1);

   // Hex glyph, segments {g..a}.
   function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0: g = 7'h3F;
         4'h1: g = 7'h06;
         4'h2: g = 7'h5B;
         4'h3: g = 7'h4F;
         4'h4: g = 7'h66;
         4'h5: g = 7'h6D;
         4'h6: g = 7'h7D;
         4'h7: g = 7'h07;
         4'h8: g = 7'h7F;
         4'h9: g = 7'h6F;
         4'hA: g = 7'h77;
         4'hB: g = 7'h7C;
         4'hC: g = 7'h39;
         4'hD: g = 7'h5E;
         4'hE: g = 7'h79;
         default: g = 7'h71;
      endcase
      return g;
   endfunction

   // Grade letter: out-of-range nibbles are dark, 7..9 = A, 4..6 = F, 0..3 = P.
   function automatic logic [6:0] grade_glyph(input logic [3:0] nib);
      logic [6:0] g;
      if (nib > 4'd9)
         g = 7'h00;
      else if (nib >= 4'd7)
         g = 7'h77;
      else if (nib >= 4'd4)
         g = 7'h71;
      else
         g = 7'h73;
      return g;
   endfunction

   // State registers
   logic [PRE_W-1:0]     pre_q, pre_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [FC_W-1:0]      fcnt_q, fcnt_d;
   logic                 phase_q, phase_d;
   logic                 pend_q, pend_d;
   logic [4*NDIGITS-1:0] shadow_q, shadow_d;
   logic [NDIGITS-1:0]   shadow_dp_q, shadow_dp_d;
   logic [4*NDIGITS-1:0] active_q, active_d;
   logic [NDIGITS-1:0]   active_dp_q, active_dp_d;
   logic                 bnd_q, bnd_d;

   // Output registers
   logic [7:0]           seg_q, seg_d;
   logic [NDIGITS-1:0]   dig_q, dig_d;
   logic                 frame_q, frame_d;

   logic                 tick;
   logic                 boundary;

   // Scan timing, tear-free buffering and blink phase
   always_comb begin
      tick        = (pre_q == PRE_LAST);
      boundary    = tick && (idx_q == IDX_LAST);

      pre_d       = tick ? '0 : pre_q + 1'b1;
      idx_d       = idx_q;
      fcnt_d      = fcnt_q;
      phase_d     = phase_q;
      pend_d      = pend_q;
      shadow_d    = shadow_q;
      shadow_dp_d = shadow_dp_q;
      active_d    = active_q;
      active_dp_d = active_dp_q;
      bnd_d       = boundary;

      if (tick)
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

      if (load) begin
         shadow_d    = value;
         shadow_dp_d = dp;
      end

      // A load on the boundary edge bypasses the shadow, so nothing is left
      // pending for the following frame.
      if (boundary) begin
         if (load) begin
            active_d    = value;
            active_dp_d = dp;
         end else if (pend_q) begin
            active_d    = shadow_q;
            active_dp_d = shadow_dp_q;
         end
         pend_d = 1'b0;
         if (fcnt_q == FC_LAST) begin
            fcnt_d  = '0;
            phase_d = ~phase_q;
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end else if (load) begin
         pend_d = 1'b1;
      end
   end

   // Digit decode for the slot currently indexed
   always_comb begin
      logic [NDIGITS-1:0] upper_zero;
      logic               zacc;
      logic [3:0]         nib_sel;
      logic               dp_sel;
      logic               blank_sel;
      logic               blink_sel;
      logic               lzs_sel;
      logic               dark;
      logic [6:0]         glyph;

      // upper_zero[k]: nibbles k..NDIGITS-1 of the active value are all zero
      zacc       = 1'b1;
      upper_zero = '0;
      for (int k = NDIGITS - 1; k >= 0; k--) begin
         zacc          = zacc & (active_q[4*k +: 4] == 4'h0);
         upper_zero[k] = zacc;
      end

      nib_sel   = active_q[3:0];
      dp_sel    = active_dp_q[0];
      blank_sel = blank[0];
      blink_sel = blink[0];
      lzs_sel   = 1'b0;
      dig_d     = '0;
      for (int k = 0; k < NDIGITS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            nib_sel   = active_q[4*k +: 4];
            dp_sel    = active_dp_q[k];
            blank_sel = blank[k];
            blink_sel = blink[k];
            lzs_sel   = (k > 0) && upper_zero[k];
            dig_d[k]  = 1'b1;
         end
      end

      glyph   = mode ? grade_glyph(nib_sel) : hex_glyph(nib_sel);
      dark    = blank_sel || (blink_sel && phase_q) || (!mode && lzs && lzs_sel);
      seg_d   = dark ? 8'h00 : {dp_sel, glyph};
      // The boundary edge moves idx to 0; the registered outputs show digit 0
      // one edge later, so the frame pulse is delayed by the same amount.
      frame_d = bnd_q;
   end

   always_ff @(posedge clk_2 or negedge reset) begin
      if (!reset) begin
         pre_q       <= '0;
         idx_q       <= '0;
         fcnt_q      <= '0;
         phase_q     <= 1'b0;
         pend_q      <= 1'b0;
         shadow_q    <= '0;
         shadow_dp_q <= '0;
         active_q    <= '0;
         active_dp_q <= '0;
         bnd_q       <= 1'b0;
         seg_q       <= 8'h00;
         dig_q       <= '0;
         frame_q     <= 1'b0;
      end else begin
         pre_q       <= pre_d;
         idx_q       <= idx_d;
         fcnt_q      <= fcnt_d;
         phase_q     <= phase_d;
         pend_q      <= pend_d;
         shadow_q    <= shadow_d;
         shadow_dp_q <= shadow_dp_d;
         active_q    <= active_d;
         active_dp_q <= active_dp_d;
         bnd_q       <= bnd_d;
         seg_q       <= seg_d;
         dig_q       <= dig_d;
         frame_q     <= frame_d;
      end
   end

   assign SEG   = seg_q;
   assign DIG   = dig_q;
   assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
module tb_seg7_scan;

   localparam int N  = 4;
   localparam int R  = 4;
   localparam int BF = 2;
   localparam int NR = N * R;

   logic          clk_2 = 1'b0;
   logic          reset = 1'b0;
   logic [15:0]   value = '0;
   logic          load  = 1'b0;
   logic [3:0]    dp    = '0;
   logic          mode  = 1'b0;
   logic [3:0]    blank = '0;
   logic [3:0]    blink = '0;
   logic          lzs   = 1'b0;
   logic [7:0]    SEG;
   logic [3:0]    DIG;
   logic          frame;

   seg7_scan #(.NDIGITS(N), .REFRESH_DIV(R), .BLINK_FRAMES(BF)) dut (
      .clk_2(clk_2), .reset(reset), .value(value), .load(load), .dp(dp),
      .mode(mode), .blank(blank), .blink(blink), .lzs(lzs),
      .SEG(SEG), .DIG(DIG), .frame(frame)
   );

   always #5 clk_2 = ~clk_2;

   int n_checks = 0;
   int n_pass   = 0;

   // Behavioural model: c = clock edges since reset release
   int          c = 0;
   logic [15:0] m_active = '0;
   logic [15:0] m_shadow = '0;
   logic [3:0]  m_adp = '0;
   logic [3:0]  m_sdp = '0;
   bit          m_pend = 0;

   bit          lit_en = 0;
   logic [7:0]  lit_exp [4];

   function automatic logic [6:0] hex_glyph(input logic [3:0] n);
      logic [6:0] t [16];
      t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      return t[n];
   endfunction

   function automatic logic [6:0] grade_glyph(input logic [3:0] n);
      if (n > 9) return 7'h00;
      if (n >= 7) return 7'h77;
      if (n >= 4) return 7'h71;
      return 7'h73;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
   endtask

   // One clock cycle: predict outputs, clock, compare, advance the model.
   task automatic step();
      logic [7:0] es;
      logic [3:0] ed;
      logic       ef;
      logic [3:0] nib;
      int         k;
      bit         ph;
      bit         dark;
      if (!reset) begin
         es = 8'h00; ed = 4'h0; ef = 1'b0;
         c = 0; m_active = '0; m_shadow = '0; m_adp = '0; m_sdp = '0; m_pend = 0;
      end else begin
         k    = (c / R) % N;
         nib  = m_active[4*k +: 4];
         ph   = (((c / NR) / BF) % 2) == 1;
         dark = blank[k] || (blink[k] && ph) ||
                (!mode && lzs && k > 0 && (m_active >> (4*k)) == 16'h0);
         es   = dark ? 8'h00 : {m_adp[k], (mode ? grade_glyph(nib) : hex_glyph(nib))};
         ed   = 4'(1 << k);
         ef   = (c > 0) && (c % NR == 0);
      end
      @(posedge clk_2);
      #1;
      check("seg", SEG, es);
      check("dig", DIG, ed);
      check("frame", frame, ef);
      if (lit_en) begin
         for (int kk = 0; kk < N; kk++)
            if (DIG == 4'(1 << kk)) check("seg_literal", SEG, lit_exp[kk]);
      end
      if (reset) begin
         if (load) begin
            m_shadow = value;
            m_sdp    = dp;
         end
         if (c % NR == NR - 1) begin
            if (load) begin
               m_active = value; m_adp = dp;
            end else if (m_pend) begin
               m_active = m_shadow; m_adp = m_sdp;
            end
            m_pend = 0;
         end else if (load) begin
            m_pend = 1;
         end
         c++;
      end
      load = 1'b0;
   endtask

   task automatic wait_frame_start();
      for (int i = 0; i < NR && (c % NR) != 0; i++) step();
   endtask

   // One full frame, each digit's SEG pinned to a hand-computed value.
   task automatic check_frame(input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3,
                              input bit do_load, input logic [15:0] lv);
      lit_exp[0] = e0; lit_exp[1] = e1; lit_exp[2] = e2; lit_exp[3] = e3;
      lit_en = 1;
      for (int i = 0; i < NR; i++) begin
         if (do_load && i == NR - 1) begin
            load  = 1'b1;
            value = lv;
         end
         step();
      end
      lit_en = 0;
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d);
      value = v;
      dp    = d;
      load  = 1'b1;
      step();
   endtask

   initial begin
      // Held in reset
      for (int i = 0; i < 3; i++) step();
      reset = 1'b1;

      // Idle scan of value 0
      check_frame(8'h3F, 8'h3F, 8'h3F, 8'h3F, 0, 16'h0);
      check_frame(8'h3F, 8'h3F, 8'h3F, 8'h3F, 0, 16'h0);

      // Mid-frame load appears only after the next boundary
      for (int i = 0; i < 5; i++) step();
      do_load(16'h9A3F, 4'h0);
      wait_frame_start();
      check_frame(8'h71, 8'h4F, 8'h77, 8'h6F, 0, 16'h0);

      // Two loads in one frame (last wins), then a load on the boundary edge
      step(); step();
      do_load(16'h1234, 4'h0);
      step(); step();
      do_load(16'h5678, 4'h0);
      wait_frame_start();
      check_frame(8'h7F, 8'h07, 8'h7D, 8'h6D, 1, 16'hC0DE);
      check_frame(8'h79, 8'h5E, 8'h3F, 8'h39, 0, 16'h0);

      // Grade mode
      mode = 1'b1;
      do_load(16'hA740, 4'h0);
      wait_frame_start();
      check_frame(8'h73, 8'h71, 8'h77, 8'h00, 0, 16'h0);

      // Leading-zero suppression
      mode = 1'b0;
      lzs  = 1'b1;
      do_load(16'h0050, 4'h0);
      wait_frame_start();
      check_frame(8'h3F, 8'h6D, 8'h00, 8'h00, 0, 16'h0);
      do_load(16'h0000, 4'h0);
      wait_frame_start();
      check_frame(8'h3F, 8'h00, 8'h00, 8'h00, 0, 16'h0);

      // Blink on digit 0 with its decimal point
      lzs   = 1'b0;
      blink = 4'b0001;
      do_load(16'h0000, 4'b0001);
      for (int i = 0; i < 4 * NR && (c % (2 * BF * NR)) != 0; i++) step();
      check_frame(8'hBF, 8'h3F, 8'h3F, 8'h3F, 0, 16'h0);
      check_frame(8'hBF, 8'h3F, 8'h3F, 8'h3F, 0, 16'h0);
      check_frame(8'h00, 8'h3F, 8'h3F, 8'h3F, 0, 16'h0);
      check_frame(8'h00, 8'h3F, 8'h3F, 8'h3F, 0, 16'h0);

      // Reset mid-blink with a load still pending
      check_frame(8'hBF, 8'h3F, 8'h3F, 8'h3F, 0, 16'h0);
      step(); step();
      do_load(16'hFFFF, 4'hF);
      reset = 1'b0;
      #1;
      check("async_reset_seg", SEG, 8'h00);
      check("async_reset_dig", DIG, 4'h0);
      check("async_reset_frame", frame, 1'b0);
      step(); step();
      reset = 1'b1;
      check_frame(8'h3F, 8'h3F, 8'h3F, 8'h3F, 0, 16'h0);

      // Randomized stimulus against the model
      for (int i = 0; i < 3000; i++) begin
         value = 16'($urandom);
         dp    = 4'($urandom);
         load  = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 15) == 0) mode = ~mode;
         if ($urandom_range(0, 15) == 0) lzs = ~lzs;
         if ($urandom_range(0, 31) == 0) blank = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'h0;
         if ($urandom_range(0, 31) == 0) blink = 4'($urandom);
         if ($urandom_range(0, 15) == 0) value = 16'($urandom_range(0, 255));
         if ($urandom_range(0, 999) == 0) reset = 1'b0;
         else reset = 1'b1;
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
